// File: rtl/stage3_pool_scheduler.sv
// stage3_pool_scheduler: frame-granular round-robin sharing of one pooling line buffer between N_REQ channels
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-high reset
//   i_req/i_valid/i_pixel           per-channel frame request, pixel valid and pixel (channel c at [c*IF_BW +: IF_BW])
//   o_ready                         per-channel ready, only the granted channel while streaming
//   o_lb_valid/o_lb_pixel           registered pixel stream into the line buffer
//   i_win_valid                     window strobe coming back from the line buffer
//   o_win_valid/o_win_ch            window strobe tagged with the owning channel
//   o_frame_done/o_done_ch/o_cnt_err end-of-frame pulse, its channel and window-count mismatch flag
//   o_busy                          scheduler is not idle
module stage3_pool_scheduler #(
    parameter int N_REQ        = 4,
    parameter int IF_BW        = 32,
    parameter int POOL_IN_SIZE = 8,
    parameter int POOL_K       = 2,
    parameter int STRIDE       = 2,
    parameter int DRAIN_CYC    = 4,
    localparam int CW          = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ-1:0]       i_valid,
    input  logic [N_REQ*IF_BW-1:0] i_pixel,
    output logic [N_REQ-1:0]       o_ready,
    output logic                   o_lb_valid,
    output logic [IF_BW-1:0]       o_lb_pixel,
    input  logic                   i_win_valid,
    output logic                   o_win_valid,
    output logic [CW-1:0]          o_win_ch,
    output logic                   o_frame_done,
    output logic [CW-1:0]          o_done_ch,
    output logic                   o_cnt_err,
    output logic                   o_busy
);
    localparam int FRAME_PIX = POOL_IN_SIZE * POOL_IN_SIZE;
    localparam int WIN_SIDE  = (POOL_IN_SIZE - POOL_K) / STRIDE + 1;
    localparam int WIN_EXP   = WIN_SIDE * WIN_SIDE;
    localparam int PCW       = $clog2(FRAME_PIX + 1);
    localparam int WCW       = $clog2(WIN_EXP + 1) + 1;
    localparam int DCW       = $clog2(DRAIN_CYC + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    grant, rr_ptr, pick, idx;
    logic [PCW-1:0]   pix_cnt;
    logic [WCW-1:0]   win_cnt;
    logic [DCW-1:0]   drain_cnt;
    logic [IF_BW-1:0] gpix;
    logic             own, accept, last_beat;

    assign own       = state == STREAM || state == DRAIN;
    assign accept    = state == STREAM && i_valid[grant];
    assign last_beat = accept && pix_cnt == PCW'(FRAME_PIX - 1);

    // Descending scan so the last hit, i.e. the nearest requester at or after rr_ptr, wins.
    always_comb begin
        pick = rr_ptr;
        idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = CW'((int'(rr_ptr) + i) % N_REQ);
            pick = i_req[idx] ? idx : pick;
        end
    end

    always_comb begin
        gpix = '0;
        for (int c = 0; c < N_REQ; c++)
            gpix = grant == CW'(c) ? i_pixel[c*IF_BW +: IF_BW] : gpix;
    end

    assign o_ready      = state == STREAM ? N_REQ'(1) << grant : '0;
    assign o_win_valid  = own && i_win_valid;
    assign o_win_ch     = own ? grant : '0;
    assign o_frame_done = state == DONE;
    assign o_done_ch    = o_frame_done ? grant : '0;
    assign o_cnt_err    = o_frame_done && win_cnt != WCW'(WIN_EXP);
    assign o_busy       = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            pix_cnt    <= '0;
            win_cnt    <= '0;
            drain_cnt  <= '0;
            o_lb_valid <= 1'b0;
            o_lb_pixel <= '0;
        end else begin
            o_lb_valid <= accept;
            if (accept) begin
                o_lb_pixel <= gpix;
                pix_cnt    <= pix_cnt + 1'b1;
            end
            if (o_win_valid && win_cnt != '1)
                win_cnt <= win_cnt + 1'b1;
            case (state)
                IDLE: if (|i_req) begin
                    grant   <= pick;
                    pix_cnt <= '0;
                    win_cnt <= '0;
                    state   <= STREAM;
                end
                STREAM: if (last_beat) begin
                    drain_cnt <= DCW'(DRAIN_CYC - 1);
                    state     <= DRAIN;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt == '0)
                        state <= DONE;
                end
                default: begin
                    rr_ptr <= grant == CW'(N_REQ - 1) ? '0 : grant + 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stage3_pool_scheduler.sv
// tb_stage3_pool_scheduler: randomized directed bench for stage3_pool_scheduler against a frame-level reference model
module tb_stage3_pool_scheduler;
    localparam int N  = 4;
    localparam int BW = 32;
    localparam int DR = 4;
    localparam int CW = $clog2(N);

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    i_req, i_valid, o_ready;
    logic [N*BW-1:0] i_pixel;
    logic            o_lb_valid, i_win_valid, o_win_valid, o_frame_done, o_cnt_err, o_busy;
    logic [BW-1:0]   o_lb_pixel;
    logic [CW-1:0]   o_win_ch, o_done_ch;

    int n_assert = 0, n_fail = 0;
    int ref_ptr, cur_ch, win_seen, gaps;
    logic prev_lb;
    logic [BW-1:0] cap[$];

    always #5 clk = ~clk;

    stage3_pool_scheduler #(.N_REQ(N), .IF_BW(BW), .POOL_IN_SIZE(8), .POOL_K(2), .STRIDE(2), .DRAIN_CYC(DR)) dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_valid(i_valid), .i_pixel(i_pixel),
        .o_ready(o_ready), .o_lb_valid(o_lb_valid), .o_lb_pixel(o_lb_pixel), .i_win_valid(i_win_valid),
        .o_win_valid(o_win_valid), .o_win_ch(o_win_ch), .o_frame_done(o_frame_done),
        .o_done_ch(o_done_ch), .o_cnt_err(o_cnt_err), .o_busy(o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++)
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (o_lb_valid) cap.push_back(o_lb_pixel);
        if (prev_lb && !o_lb_valid) gaps++;
        prev_lb = o_lb_valid;
        if (o_win_valid) begin
            win_seen++;
            chk("win_ch", o_win_ch, cur_ch);
        end
        chk("ready_onehot", $countones(o_ready) <= 1, 1);
    end

    task automatic run_frame(input bit bubbles, input bit skip, input int drop_at, input int abort_at);
        int ch, n, beats, cyc;
        bit acc;
        logic [BW-1:0] data[64];
        ch = ref_pick(i_req, ref_ptr);
        cur_ch = ch;
        for (int k = 0; k < 64; k++) data[k] = $urandom;
        cap.delete();
        win_seen = 0;
        gaps = 0;
        n = 0;
        while (o_ready === '0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("grant", o_ready, 1 << ch);
        beats = 0;
        cyc = 0;
        while (beats < 64 && cyc < 400) begin
            for (int c = 0; c < N; c++) i_pixel[c*BW +: BW] = $urandom;
            i_pixel[ch*BW +: BW] = data[beats];
            i_valid = N'($urandom);
            i_valid[ch] = bubbles ? ~cyc[0] : 1'b1;
            i_win_valid = i_valid[ch] && beats % 4 == 3 && beats < 60 && !(skip && beats == 31);
            acc = i_valid[ch] && o_ready[ch];
            chk("ready_hold", o_ready, 1 << ch);
            @(posedge clk); #1;
            if (acc) beats++;
            if (drop_at > 0 && beats == drop_at) i_req[ch] = 1'b0;
            if (abort_at > 0 && beats == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_outs", {o_ready, o_lb_valid, o_lb_pixel, o_win_valid, o_win_ch,
                                   o_frame_done, o_done_ch, o_cnt_err, o_busy}, 0);
                i_valid = '0;
                i_win_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                ref_ptr = 0;
                return;
            end
            cyc++;
        end
        chk("beats", beats, 64);
        i_valid = '0;
        i_win_valid = 1'b1;
        #1;
        chk("ready_off", o_ready, 0);
        chk("drain_win", {o_win_valid, o_win_ch}, {1'b1, CW'(ch)});
        n = 0;
        while (o_frame_done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            i_win_valid = 1'b0;
            n++;
        end
        chk("done_lat", n, DR);
        chk("done_ch", o_done_ch, ch);
        chk("cnt_err", o_cnt_err, skip);
        chk("busy", o_busy, 1);
        ref_ptr = (ch + 1) % N;
        chk("win_count", win_seen, skip ? 15 : 16);
        chk("pix_count", cap.size(), 64);
        for (int k = 0; k < 64 && k < cap.size(); k++) chk("pix", cap[k], data[k]);
        chk("pix_hold", o_lb_pixel, data[63]);
        chk("gaps", gaps, bubbles ? 64 : 1);
    endtask

    initial begin
        reset = 1'b1;
        i_req = '0;
        i_valid = '0;
        i_pixel = '0;
        i_win_valid = 1'b0;
        ref_ptr = 0;
        cur_ch = 0;
        prev_lb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {o_ready, o_lb_valid, o_lb_pixel, o_win_valid, o_win_ch,
                           o_frame_done, o_done_ch, o_cnt_err, o_busy}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", o_busy, 0);
        i_win_valid = 1'b1;
        #1;
        chk("stray_win", o_win_valid, 0);
        i_win_valid = 1'b0;
        i_req = 4'b0001;
        @(posedge clk); #1;
        chk("req_lat", o_ready, 4'b0001);
        run_frame(0, 0, 0, 0);
        i_req = 4'b1111;
        repeat (5) run_frame(0, 0, 0, 0);
        run_frame(1, 0, 0, 0);
        run_frame(0, 1, 0, 0);
        for (int r = 0; r < 4; r++) begin
            i_req = N'($urandom_range(1, 15));
            run_frame(1'($urandom_range(0, 1)), 0, 10, 0);
        end
        i_req = 4'b0010;
        run_frame(0, 0, 0, 0);
        i_req = 4'b0100;
        run_frame(0, 0, 0, 30);
        i_req = 4'b1111;
        run_frame(0, 0, 0, 0);
        i_req = '0;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/stage3_pool_scheduler.md
# stage3_pool_scheduler

Frame-granular round-robin scheduler that shares one `stage3_line_buffer` (POOL_K×POOL_K window generator feeding the pooling stage) between N_REQ feature-map channels. It grants one channel at a time for a full POOL_IN_SIZE×POOL_IN_SIZE frame and forwards that channel's pixels to the line buffer. It then drains the buffer pipeline, tags every emitted window with the owning channel, and checks the window count before moving to the next requester.

## Interface
- N_REQ, 4, number of requesting channels (≥2)
- IF_BW, 32, pixel width
- POOL_IN_SIZE, 8, frame side length
- POOL_K, 2, window side
- STRIDE, 2, window stride
- DRAIN_CYC, 4, cycles waited after the last pixel leaves; must be ≥ line-buffer latency + 1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  N_REQ  per-channel frame request, level; held until the frame completes
- i_valid  in  N_REQ  per-channel pixel valid
- i_pixel  in  N_REQ*IF_BW  per-channel pixel; channel c occupies bits [c*IF_BW +: IF_BW]
- o_ready  out  N_REQ  per-channel ready; at most one bit high
- o_lb_valid  out  1  pixel valid to line buffer (i_in_valid)
- o_lb_pixel  out  IF_BW  pixel to line buffer (i_in_pixel)
- i_win_valid  in  1  window valid from line buffer (o_window_valid)
- o_win_valid  out  1  i_win_valid gated by ownership (STREAM/DRAIN only)
- o_win_ch  out  $clog2(N_REQ)  channel owning the current window
- o_frame_done  out  1  one-cycle pulse at end of frame
- o_done_ch  out  $clog2(N_REQ)  channel of the completed frame, valid with o_frame_done
- o_cnt_err  out  1  one-cycle pulse with o_frame_done when the window count mismatches
- o_busy  out  1  high in every state except IDLE

## Operation
- FRAME_PIX = POOL_IN_SIZE²; WIN_EXP = ((POOL_IN_SIZE−POOL_K)/STRIDE+1)². Defaults: 64 and 16.
- States: IDLE → STREAM → DRAIN → DONE → IDLE.
- IDLE: if any i_req bit is high, pick the first requester at or after rr_ptr (cyclic search), latch it as grant, clear pix_cnt and win_cnt, go to STREAM. With no request, stay in IDLE.
- STREAM: o_ready[grant]=1 and all other ready bits are 0. A beat is accepted when i_valid[grant] & o_ready[grant]; each accepted beat increments pix_cnt. When a beat is accepted with pix_cnt==FRAME_PIX−1, go to DRAIN and load drain_cnt=DRAIN_CYC−1.
- DRAIN: ready bits are all 0. drain_cnt decrements each cycle; at 0, go to DONE.
- DONE (one cycle): pulse o_frame_done, drive o_done_ch=grant, set o_cnt_err=(win_cnt≠WIN_EXP), set rr_ptr=grant+1 mod N_REQ, go to IDLE.
- Windows: in STREAM or DRAIN, o_win_valid=i_win_valid, o_win_ch=grant, and each i_win_valid increments win_cnt (saturating at its max). Outside those states, o_win_valid=0 and i_win_valid is ignored.
- Frames are atomic. Dropping i_req mid-frame has no effect; the frame completes only after FRAME_PIX beats. This keeps the line buffer's x/y counters frame-aligned.
- Non-granted channels see o_ready=0 and their i_valid is ignored.
- Counter widths: pix_cnt is $clog2(FRAME_PIX+1) bits; win_cnt is $clog2(WIN_EXP+1)+1 bits.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant=0, all counters 0. All outputs are 0: o_ready, o_lb_valid, o_lb_pixel, o_win_valid, o_win_ch, o_frame_done, o_done_ch, o_cnt_err, o_busy.
- o_ready is a decode of registered state/grant; it does not combinationally depend on i_valid.
- o_lb_valid/o_lb_pixel are registered: an accepted beat at cycle t appears at t+1. When no beat is accepted, o_lb_valid=0 and o_lb_pixel holds its last value.
- Request to first ready: i_req seen in IDLE at t, o_ready high at t+1.
- Last beat accepted at t: o_ready low from t+1, DRAIN from t+1 to t+DRAIN_CYC, o_frame_done at t+DRAIN_CYC+1. The next grant can be in STREAM at t+DRAIN_CYC+3.
- o_win_valid/o_win_ch are combinational from i_win_valid and state (zero latency).
- If reset asserts mid-frame, return immediately to the reset state. The line buffer must be reset by the same event; a partial frame is discarded.

## Test plan
- Single channel: i_req=0001, 64 pixels with value p=k, i_valid always high → o_lb_valid for 64 consecutive cycles carrying 0..63; 16 o_win_valid pulses with o_win_ch=0; o_frame_done with o_done_ch=0 and o_cnt_err=0.
- Round-robin: i_req=1111 held → grant order 0,1,2,3,0; exactly one ready bit high at any time; four o_frame_done pulses with o_done_ch=0,1,2,3.
- Bubbles: granted i_valid toggles 1/0 → exactly 64 beats forwarded in order, pix_cnt stops at 64, the frame completes, and gaps appear on o_lb_valid.
- Count error: suppress i_win_valid for one expected window → o_cnt_err=1 coincident with o_frame_done. A stray i_win_valid in IDLE → o_win_valid=0.
- Request drop: deassert i_req[grant] after 10 beats → ready stays on that channel until 64 beats, then the next requester is granted.
- Reset at beat 30 → all outputs 0 on the next sample. A fresh request then restarts from pix_cnt=0 with rr_ptr=0.
